// File: rtl/unidade_load_store.sv
// Load/store unit: sequences byte/halfword/word accesses onto a word-wide
// data memory, with read-modify-write for sub-word stores and fault detection.
module unidade_load_store #(
    parameter int unsigned PALAVRAS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Inicia,
    input  logic        EhStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Endereco,
    input  logic [31:0] DadoStore,
    output logic [31:0] DadoCarregado,
    output logic        Ocupado,
    output logic        Pronto,
    output logic        Excecao,
    output logic        MemLe,
    output logic        MemEscreve,
    output logic [31:0] MemEndereco,
    output logic [31:0] MemDadoEscrita,
    input  logic [31:0] MemDadoLido
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ESCRITA = 2'd2,
        CONCLUI = 2'd3
    } estado_t;

    estado_t     estado;
    logic        ehStoreReg;
    logic [2:0]  funct3Reg;
    logic [31:0] enderecoReg;
    logic [31:0] dadoStoreReg;
    logic [31:0] buffer;

    logic        falha;
    logic [31:0] palavraDeslocada;
    logic [31:0] resultadoCarga;
    logic [31:0] mascara;
    logic [31:0] dadoAlinhado;
    logic [31:0] palavraEscrita;

    // Fault check on the incoming request, evaluated at latch time
    always_comb begin
        falha = 1'b0;
        case (Funct3)
            F3_B:    falha = 1'b0;
            F3_H:    falha = Endereco[0];
            F3_W:    falha = (Endereco[1:0] != 2'b00);
            F3_BU:   falha = EhStore;
            F3_HU:   falha = EhStore | Endereco[0];
            default: falha = 1'b1;
        endcase
        if ({2'b00, Endereco[31:2]} >= 32'(PALAVRAS)) begin
            falha = 1'b1;
        end
    end

    // Lane select and extension of the word arriving in LEITURA
    always_comb begin
        palavraDeslocada = MemDadoLido >> {enderecoReg[1:0], 3'b000};
        case (funct3Reg)
            F3_B:    resultadoCarga = {{24{palavraDeslocada[7]}}, palavraDeslocada[7:0]};
            F3_H:    resultadoCarga = {{16{palavraDeslocada[15]}}, palavraDeslocada[15:0]};
            F3_BU:   resultadoCarga = {24'd0, palavraDeslocada[7:0]};
            F3_HU:   resultadoCarga = {16'd0, palavraDeslocada[15:0]};
            default: resultadoCarga = MemDadoLido;
        endcase
    end

    // Merge store data into the buffered word; sw overwrites every lane
    always_comb begin
        case (funct3Reg)
            F3_B: begin
                mascara      = 32'h0000_00FF << {enderecoReg[1:0], 3'b000};
                dadoAlinhado = {4{dadoStoreReg[7:0]}};
            end
            F3_H: begin
                mascara      = 32'h0000_FFFF << {enderecoReg[1], 4'b0000};
                dadoAlinhado = {2{dadoStoreReg[15:0]}};
            end
            default: begin
                mascara      = 32'hFFFF_FFFF;
                dadoAlinhado = dadoStoreReg;
            end
        endcase
        palavraEscrita = (buffer & ~mascara) | (dadoAlinhado & mascara);
    end

    // Memory-side strobes decode straight from the state so reset kills them at once
    always_comb begin
        Ocupado        = (estado != OCIOSO);
        MemLe          = (estado == LEITURA);
        MemEscreve     = (estado == ESCRITA);
        MemEndereco    = 32'd0;
        MemDadoEscrita = 32'd0;
        if (estado == LEITURA || estado == ESCRITA) begin
            MemEndereco = {enderecoReg[31:2], 2'b00};
        end
        if (estado == ESCRITA) begin
            MemDadoEscrita = palavraEscrita;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            ehStoreReg    <= 1'b0;
            funct3Reg     <= 3'd0;
            enderecoReg   <= 32'd0;
            dadoStoreReg  <= 32'd0;
            buffer        <= 32'd0;
            DadoCarregado <= 32'd0;
            Excecao       <= 1'b0;
            Pronto        <= 1'b0;
        end else begin
            Pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (Inicia) begin
                        ehStoreReg   <= EhStore;
                        funct3Reg    <= Funct3;
                        enderecoReg  <= Endereco;
                        dadoStoreReg <= DadoStore;
                        Excecao      <= falha;
                        if (falha) begin
                            estado <= CONCLUI;
                            Pronto <= 1'b1;
                        end else if (EhStore && Funct3 == F3_W) begin
                            estado <= ESCRITA;
                        end else begin
                            estado <= LEITURA;
                        end
                    end
                end
                LEITURA: begin
                    buffer <= MemDadoLido;
                    if (ehStoreReg) begin
                        estado <= ESCRITA;
                    end else begin
                        estado        <= CONCLUI;
                        Pronto        <= 1'b1;
                        DadoCarregado <= resultadoCarga;
                    end
                end
                ESCRITA: begin
                    estado <= CONCLUI;
                    Pronto <= 1'b1;
                end
                CONCLUI: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule
